// File: rtl/elastic_pipe_reg.sv
// elastic_pipe_reg: DEPTH-stage valid/ready pipeline register with one skid entry and synchronous flush
module elastic_pipe_reg #(
  parameter int WDATA = 32,
  parameter int DEPTH = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WDATA-1:0]              din,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WDATA-1:0]              dout,
  output logic [$clog2(DEPTH+2)-1:0]    occupancy
);
  localparam int OW = $clog2(DEPTH+2);
  logic [DEPTH-1:0] v, adv;
  logic [WDATA-1:0] d [DEPTH];
  logic             sv;
  logic [WDATA-1:0] sd;
  logic             acc, load0, in_fire, out_fire;
  assign in_ready  = !sv && !clr;
  assign in_fire   = in_valid && in_ready;
  assign out_valid = v[DEPTH-1];
  assign out_fire  = out_valid && out_ready;
  assign dout      = d[DEPTH-1];
  // adv[k]: the entry in stage k moves forward this cycle (a hole or a departure exists downstream)
  always_comb begin
    acc = out_ready || !v[DEPTH-1];
    adv = '0;
    adv[DEPTH-1] = acc;
    for (int k = DEPTH-2; k >= 0; k--) begin
      acc = acc || !v[k+1];
      adv[k] = acc;
    end
  end
  // an empty S0 can always take new data, even when everything behind it is stalled
  assign load0 = adv[0] || !v[0];
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      v         <= '0;
      sv        <= 1'b0;
      sd        <= '0;
      occupancy <= '0;
      for (int k = 0; k < DEPTH; k++) d[k] <= '0;
    end else begin
      if (load0) begin
        v[0] <= sv || in_fire;
        d[0] <= sv ? sd : din;
      end
      for (int k = 1; k < DEPTH; k++)
        if (adv[k-1]) begin
          v[k] <= v[k-1];
          d[k] <= d[k-1];
        end
      sv <= (sv || in_fire) && !load0;
      if (in_fire && !load0) sd <= din;
      occupancy <= occupancy + OW'(in_fire) - OW'(out_fire);
    end
  end
endmodule
